// File: rtl/mem_access_wb.sv
`default_nettype none
// ============================================================================
// mem_access_wb : memory-access stage + MEM/WB register, req/ack data memory.
// Optional MEM_TIMEOUT_EN adds a BUSY watchdog that sets sticky err_o.
// Rev 1.0
// ============================================================================
module mem_access_wb #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        RegWrite_i,
  input  logic        MemtoReg_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] ALUout_i,
  input  logic [31:0] rs2_data_i,
  input  logic [4:0]  rd_addr_i,
  output logic        stall_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        RegWrite_o,
  output logic        MemtoReg_o,
  output logic [31:0] ALUout_o,
  output logic [31:0] mem_data_o,
  output logic [4:0]  rd_addr_o,
  output logic        err_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      next_state;
  logic        mem_op;
  logic        is_load;
  logic        timeout;
  logic [31:0] rdata;

  // A combined read+write is handled as a store.
  assign mem_op  = MemRead_i | MemWrite_i;
  assign is_load = MemRead_i & ~MemWrite_i;

`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] tmo_cnt;
  logic       err;

  // An ack arriving in the final BUSY cycle takes priority over the abort.
  assign timeout = (state == BUSY) && !mem_ack_i && (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      tmo_cnt <= 8'd0;
      err     <= 1'b0;
    end else begin
      if (state != BUSY) begin
        tmo_cnt <= 8'd0;
      end else if (!mem_ack_i) begin
        tmo_cnt <= tmo_cnt + 8'd1;
      end
      if (timeout) begin
        err <= 1'b1;
      end
    end
  end

  assign err_o = err;
`else
  assign timeout = 1'b0;
  assign err_o   = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    stall_o    = 1'b0;
    case (state)
      IDLE: begin
        if (mem_op) begin
          stall_o    = 1'b1;
          next_state = BUSY;
        end
      end
      BUSY: begin
        stall_o = 1'b1;
        if (mem_ack_i || timeout) begin
          next_state = DONE;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Memory-side request registers and captured load data.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= 32'd0;
      mem_wdata_o <= 32'd0;
      rdata       <= 32'd0;
    end else begin
      if (state == IDLE && mem_op) begin
        mem_req_o   <= 1'b1;
        mem_we_o    <= MemWrite_i;
        mem_addr_o  <= ALUout_i;
        mem_wdata_o <= rs2_data_i;
      end else if (state == BUSY && (mem_ack_i || timeout)) begin
        mem_req_o <= 1'b0;
        if (mem_ack_i) begin
          if (!mem_we_o) begin
            rdata <= mem_rdata_i;
          end
        end else begin
          rdata <= 32'd0;
        end
      end
    end
  end

  // MEM/WB register: stalled edges insert a bubble and keep the data fields.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      RegWrite_o <= 1'b0;
      MemtoReg_o <= 1'b0;
      ALUout_o   <= 32'd0;
      mem_data_o <= 32'd0;
      rd_addr_o  <= 5'd0;
    end else if (!stall_o) begin
      RegWrite_o <= RegWrite_i;
      MemtoReg_o <= MemtoReg_i;
      ALUout_o   <= ALUout_i;
      mem_data_o <= is_load ? rdata : 32'd0;
      rd_addr_o  <= rd_addr_i;
    end else begin
      RegWrite_o <= 1'b0;
      MemtoReg_o <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: doc/mem_access_wb.md
# mem_access_wb

Memory-access stage plus MEM/WB pipeline register, directly downstream of the EX/MEM register. It consumes the EX/MEM control, ALU result, store data and destination register, and drives a multi-cycle data memory through a request/acknowledge handshake. It stalls the upstream pipeline while an access is outstanding and presents the registered write-back bundle to the WB stage.

## Interface

**Parameters**
- `TIMEOUT_CYCLES`, default 255: maximum BUSY cycles before abort. Used only with `MEM_TIMEOUT_EN`; range 1–255; 8-bit counter.

**Ports**
- `clk_i` in 1: clock; all state changes on the rising edge.
- `rst_i` in 1: reset, asynchronous, active-low.
- `RegWrite_i`, `MemtoReg_i`, `MemRead_i`, `MemWrite_i` in 1 each: control from EX/MEM.
- `ALUout_i` in 32: ALU result; also the memory byte address.
- `rs2_data_i` in 32: store data.
- `rd_addr_i` in 5: destination register.
- `stall_o` out 1: freeze PC/IF/ID/EX/MEM registers (combinational).
- `mem_req_o` out 1: memory request (registered).
- `mem_we_o` out 1: 1 = write, 0 = read (registered).
- `mem_addr_o` out 32: access address (registered).
- `mem_wdata_o` out 32: write data (registered).
- `mem_ack_i` in 1: memory completion, single-cycle pulse.
- `mem_rdata_i` in 32: read data, valid when `mem_ack_i` = 1.
- `RegWrite_o`, `MemtoReg_o` out 1 each: MEM/WB control.
- `ALUout_o` out 32: MEM/WB ALU result.
- `mem_data_o` out 32: MEM/WB load data.
- `rd_addr_o` out 5: MEM/WB destination.
- `err_o` out 1: sticky timeout flag.

## Operation

**FSM states:** IDLE, BUSY, DONE.

- **IDLE**
  - If `MemRead_i` or `MemWrite_i` is set: `stall_o` = 1.
  - At the next edge: latch `mem_addr_o` = `ALUout_i`, `mem_wdata_o` = `rs2_data_i`, `mem_we_o` = `MemWrite_i`; set `mem_req_o` = 1; go to BUSY.
  - Otherwise: `stall_o` = 0.
- **BUSY**
  - `stall_o` = 1 and `mem_req_o` = 1.
  - On `mem_ack_i`: capture `mem_rdata_i` into the internal `rdata` register (loads only), clear `mem_req_o`, go to DONE.
- **DONE**
  - `stall_o` = 0.
  - At the next edge: MEM/WB loads the instruction; return to IDLE.
- **MEM/WB register**
  - Loads every edge on which `stall_o` = 0.
  - `RegWrite_o`, `MemtoReg_o`, `ALUout_o`, `rd_addr_o` come from the inputs.
  - `mem_data_o` = `rdata` for a load, 0 otherwise.
  - On edges with `stall_o` = 1 it loads a bubble: `RegWrite_o` = 0, `MemtoReg_o` = 0; data fields hold their values.
- **Upstream rule:** EX/MEM inputs are held stable while `stall_o` = 1. This block never re-issues an access for the same instruction, because upstream advances at the DONE edge.
- **Ignored inputs:** `mem_ack_i` outside BUSY; `mem_rdata_i` for stores.
- **Both `MemRead_i` and `MemWrite_i` set:** treated as a write.

## Timing

- **Reset (`rst_i` = 0, asynchronous):** state = IDLE; all outputs 0, including `mem_req_o`, `err_o`, `stall_o` (IDLE with ops cleared), the internal `rdata` and the timeout counter.
- **Reset mid-access:** the request drops immediately; a late ack is ignored.
- **Non-memory instruction:** 1 cycle; MEM/WB valid on the edge after presentation.
- **Memory access with ack in BUSY cycle k (k ≥ 1):**
  - Stall cycles = k + 1 (IDLE cycle plus k BUSY cycles).
  - MEM/WB valid after the edge ending DONE.
  - Minimum total latency: 3 cycles.
- **`mem_req_o`** rises on the edge entering BUSY and falls on the edge leaving it. It is never asserted in IDLE or DONE.
- **Back-to-back accesses:** a mem instruction arriving right after DONE starts in IDLE the following cycle; there is no extra gap.

## Configuration

- **`MEM_TIMEOUT_EN` defined:**
  - An 8-bit counter clears on entry to BUSY and increments each BUSY cycle without ack.
  - When the count reaches `TIMEOUT_CYCLES` without ack: go to DONE, `rdata` = 0, `err_o` set (sticky until reset), `mem_req_o` cleared.
  - An ack in the same cycle as the timeout wins: normal completion, no error.
- **`MEM_TIMEOUT_EN` undefined:** no counter; BUSY waits indefinitely; `err_o` tied to 0.

## Test plan

- **Reset:** assert `rst_i` = 0 mid-BUSY → same cycle `mem_req_o` = 0 and all outputs 0; after release with no op, `stall_o` = 0.
- **ALU pass-through:** `RegWrite_i` = 1, `ALUout_i` = 0x0000_00A5, `rd_addr_i` = 7 → next edge `RegWrite_o` = 1, `ALUout_o` = 0xA5, `rd_addr_o` = 7, `stall_o` never 1.
- **Load:** `MemRead_i` = 1, `MemtoReg_i` = 1, `ALUout_i` = 0x100; ack at BUSY cycle 3 with `mem_rdata_i` = 0xCAFE_F00D → `mem_addr_o` = 0x100, `mem_we_o` = 0, `stall_o` high 4 cycles, `RegWrite_o` = 0 during stall, then `mem_data_o` = 0xCAFEF00D with `MemtoReg_o` = 1.
- **Store then load back-to-back:** store `rs2_data_i` = 0x1234_5678 to 0x40, ack immediate → `mem_we_o` = 1, `mem_wdata_o` = 0x12345678, `mem_data_o` = 0; the load then issues the cycle after DONE.
- **Stray ack:** pulse `mem_ack_i` in IDLE and DONE → no state change, no data capture.
- **Timeout (`MEM_TIMEOUT_EN`, `TIMEOUT_CYCLES` = 4):** load never acked → DONE after 4 BUSY cycles, `err_o` = 1 stays set, `mem_data_o` = 0. Repeat with ack on cycle 4 → `err_o` = 0.
